// File: rtl/console_arbiter_if.sv
// Console arbiter bus: FIFO read side and UART transmit side bundled together.
// master = arbiter, slave = FIFO bank plus UART transmitter.
interface console_arbiter_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8
);
   localparam int GW = $clog2(N_CH);

   logic [N_CH-1:0]       fifo_empty;
   logic [N_CH*WIDTH-1:0] fifo_data;
   logic [N_CH-1:0]       fifo_advance;
   logic                  tx_busy;
   logic                  tx_start;
   logic [WIDTH-1:0]      tx_data;
   logic [GW-1:0]         grant;
   logic                  active;

   modport master (
      input  fifo_empty, fifo_data, tx_busy,
      output fifo_advance, tx_start, tx_data, grant, active
   );

   modport slave (
      output fifo_empty, fifo_data, tx_busy,
      input  fifo_advance, tx_start, tx_data, grant, active
   );
endinterface

// File: rtl/console_arbiter.sv
// Round-robin arbiter that drains N_CH console FIFOs into a single UART transmitter in bursts.
// Defining CONSOLE_TAG_EN prefixes each channel switch with an ASCII channel tag byte ('0'..'7').
module console_arbiter #(
   parameter int N_CH      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   console_arbiter_if.master bus
);
   localparam int GW = $clog2(N_CH);
   localparam int BW = $clog2(MAX_BURST + 1);

`ifdef CONSOLE_TAG_EN
   typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, DATA = 2'd2, ACK = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2, ACK = 2'd3} state_t;
`endif

   state_t           state_r, state_s;
   logic [GW-1:0]    grant_r, grant_s;
   logic [GW-1:0]    last_grant_r, last_grant_s;
   logic             active_r, active_s;
   logic [BW-1:0]    burst_cnt_r, burst_cnt_s;
   logic [1:0]       settle_cnt_r, settle_cnt_s;
   logic             tx_start_r, tx_start_s;
   logic [WIDTH-1:0] tx_data_r, tx_data_s;
   logic [N_CH-1:0]  fifo_advance_r, fifo_advance_s;
   logic [WIDTH-1:0] ch_data_s [N_CH];
   logic [GW:0]      rr_sum_s;
   logic [GW-1:0]    rr_cand_s, rr_idx_s;
   logic             rr_found_s;
   logic             ready_s;
`ifdef CONSOLE_TAG_EN
   logic [GW-1:0]    last_tx_ch_r, last_tx_ch_s;
   logic             last_tx_vld_r, last_tx_vld_s;
   logic [7:0]       tag_s;

   assign tag_s = 8'h30 + 8'(grant_r);
`endif

   for (genvar k = 0; k < N_CH; k++) begin : g_split
      assign ch_data_s[k] = bus.fifo_data[k*WIDTH +: WIDTH];
   end

   // Transfers wait for an idle UART, no start still in flight, and a settled FIFO read path.
   assign ready_s = !bus.tx_busy && !tx_start_r && (settle_cnt_r == 2'd0);

   // Round-robin search for the first non-empty channel after last_grant.
   always_comb begin
      rr_found_s = 1'b0;
      rr_idx_s   = '0;
      rr_sum_s   = '0;
      rr_cand_s  = '0;
      for (int i = 1; i <= N_CH; i++) begin
         rr_sum_s   = {1'b0, last_grant_r} + (GW+1)'(i);
         rr_cand_s  = (rr_sum_s >= (GW+1)'(N_CH)) ? GW'(rr_sum_s - (GW+1)'(N_CH)) : GW'(rr_sum_s);
         rr_idx_s   = (!rr_found_s && !bus.fifo_empty[rr_cand_s]) ? rr_cand_s : rr_idx_s;
         rr_found_s = rr_found_s | !bus.fifo_empty[rr_cand_s];
      end
   end

   // Next-state and next-output logic of the arbitration FSM.
   always_comb begin
      state_s        = state_r;
      grant_s        = grant_r;
      last_grant_s   = last_grant_r;
      active_s       = active_r;
      burst_cnt_s    = burst_cnt_r;
      settle_cnt_s   = (settle_cnt_r != 2'd0) ? (settle_cnt_r - 2'd1) : 2'd0;
      tx_start_s     = 1'b0;
      tx_data_s      = tx_data_r;
      fifo_advance_s = '0;
`ifdef CONSOLE_TAG_EN
      last_tx_ch_s   = last_tx_ch_r;
      last_tx_vld_s  = last_tx_vld_r;
`endif
      case (state_r)
         IDLE: begin
            // settle gate keeps a just-drained channel's stale empty flag out of the search
            if (rr_found_s && (settle_cnt_r == 2'd0)) begin
               grant_s     = rr_idx_s;
               active_s    = 1'b1;
               burst_cnt_s = '0;
`ifdef CONSOLE_TAG_EN
               if (!last_tx_vld_r || (last_tx_ch_r != rr_idx_s)) begin
                  state_s = TAG;
               end else begin
                  state_s = DATA;
               end
`else
               state_s = DATA;
`endif
            end else begin
               active_s = 1'b0;
            end
         end
`ifdef CONSOLE_TAG_EN
         TAG: begin
            if (ready_s) begin
               tx_start_s    = 1'b1;
               tx_data_s     = WIDTH'(tag_s);
               last_tx_ch_s  = grant_r;
               last_tx_vld_s = 1'b1;
               state_s       = ACK;
            end else begin
               state_s = TAG;
            end
         end
`endif
         DATA: begin
            if (!ready_s) begin
               state_s = DATA;
            end else if (bus.fifo_empty[grant_r]) begin
               last_grant_s = grant_r;
               active_s     = 1'b0;
               state_s      = IDLE;
            end else begin
               tx_start_s     = 1'b1;
               tx_data_s      = ch_data_s[grant_r];
               fifo_advance_s = {{(N_CH-1){1'b0}}, 1'b1} << grant_r;
               burst_cnt_s    = burst_cnt_r + BW'(1);
               settle_cnt_s   = 2'd2;
               state_s        = ACK;
            end
         end
         ACK: begin
            if (burst_cnt_r == BW'(MAX_BURST)) begin
               last_grant_s = grant_r;
               active_s     = 1'b0;
               state_s      = IDLE;
            end else begin
               state_s = DATA;
            end
         end
         default: begin
            active_s = 1'b0;
            state_s  = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         grant_r        <= '0;
         last_grant_r   <= GW'(N_CH - 1);
         active_r       <= 1'b0;
         burst_cnt_r    <= '0;
         settle_cnt_r   <= 2'd0;
         tx_start_r     <= 1'b0;
         tx_data_r      <= '0;
         fifo_advance_r <= '0;
`ifdef CONSOLE_TAG_EN
         last_tx_ch_r   <= '0;
         last_tx_vld_r  <= 1'b0;
`endif
      end else begin
         state_r        <= state_s;
         grant_r        <= grant_s;
         last_grant_r   <= last_grant_s;
         active_r       <= active_s;
         burst_cnt_r    <= burst_cnt_s;
         settle_cnt_r   <= settle_cnt_s;
         tx_start_r     <= tx_start_s;
         tx_data_r      <= tx_data_s;
         fifo_advance_r <= fifo_advance_s;
`ifdef CONSOLE_TAG_EN
         last_tx_ch_r   <= last_tx_ch_s;
         last_tx_vld_r  <= last_tx_vld_s;
`endif
      end
   end

   assign bus.tx_start     = tx_start_r;
   assign bus.tx_data      = tx_data_r;
   assign bus.fifo_advance = fifo_advance_r;
   assign bus.grant        = grant_r;
   assign bus.active       = active_r;
endmodule
